apu_channel_mixer: RTL and testbench
====================================

# apu_channel_mixer

Parametrised, time-multiplexed mixer for the audio processing unit. It replaces the fixed four-channel combinational sum with:

- N channels;
- per-channel programmable volume;
- saturating output with clip flag;
- strobe-driven mixing pass that processes one channel per clock.

It sits between the channel generators and the DAC/PWM stage and is fired once per audio sample period by the timing strobe.

## Interface

Parameters:

- NUM_CHANNELS, default 4: number of input channels; must be ≥ 1.
- SAMPLE_W, default 9: unsigned width of each channel sample.
- VOL_W, default 4: volume width; value 2^(VOL_W-1) is unity gain, 0 is mute.
- OUT_W, default 10: unsigned width of the mixed output.
- ADDR_W, default 2: volume address width; must be ≥ max(1, clog2(NUM_CHANNELS)).

Ports:

- i_clk  in  1  sole clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_samples  in  NUM_CHANNELS*SAMPLE_W  channel k occupies [k*SAMPLE_W +: SAMPLE_W].
- i_mixer  in  NUM_CHANNELS  per-channel enable mask; bit k enables channel k.
- i_sample_stb  in  1  starts a mixing pass.
- i_vol_we  in  1  volume write enable.
- i_vol_addr  in  ADDR_W  channel index for the volume write.
- i_vol_data  in  VOL_W  volume value to write.
- o_sample  out  OUT_W  mixed, saturated sample; holds its value between passes.
- o_sample_valid  out  1  one-cycle pulse when o_sample updates.
- o_clip  out  1  set if the latest pass saturated; updates together with o_sample.
- o_busy  out  1  high while a pass is in progress.
- o_overrun  out  1  one-cycle pulse when a strobe is dropped.

## Operation

State machine states:

- IDLE: on i_sample_stb, snapshot i_samples and i_mixer, clear the accumulator, set idx=0, go to ACCUM.
- ACCUM: one channel per cycle.
  - term = mask[idx] ? (sample[idx] * vol[idx]) >> (VOL_W-1) : 0.
  - acc += term, idx++.
  - After idx = NUM_CHANNELS-1, go to DONE.
- DONE:
  - o_sample = (acc > 2^OUT_W-1) ? 2^OUT_W-1 : acc[OUT_W-1:0].
  - o_clip = (acc > 2^OUT_W-1).
  - Pulse o_sample_valid for one cycle.
  - Go to IDLE.

Arithmetic:

- The accumulator is SAMPLE_W+VOL_W+clog2(NUM_CHANNELS)+1 bits wide and never wraps.
- All arithmetic is unsigned; the shift truncates.

Volume registers:

- One register of VOL_W bits per channel; the reset value is 2^(VOL_W-1).
- A write to address ≥ NUM_CHANNELS is ignored.
- Each volume is read in that channel's own ACCUM cycle.
- A write landing in the same cycle as the read of that channel uses the old value; the new value applies from the next pass.

Strobe handling:

- i_sample_stb while o_busy=1 is dropped, pulses o_overrun, and leaves the pass undisturbed.
- o_busy is high in ACCUM and DONE.

Reset:

- Clears all state; reset mid-pass aborts it with no o_sample_valid.
- Values after reset: o_sample=0, o_sample_valid=0, o_clip=0, o_busy=0, o_overrun=0, state IDLE, volumes at unity.

## Timing

- A strobe accepted in cycle 0 occupies ACCUM in cycles 1..NUM_CHANNELS; the DONE state is cycle NUM_CHANNELS+1.
- o_sample_valid and the updated o_sample/o_clip are visible in cycle NUM_CHANNELS+2.
- o_busy is high from cycle 1 through cycle NUM_CHANNELS+1.
- A new strobe is accepted from cycle NUM_CHANNELS+2 onward, which gives a minimum strobe period of NUM_CHANNELS+2 cycles.
- o_overrun asserts the cycle after the dropped strobe.

## Configuration

APU_MIXER_VOL_RAMP_EN:

- Defined:
  - Writes set a per-channel target register.
  - When a strobe is accepted, each effective volume steps ±1 toward its target before the pass uses it.
  - This gives click-free fades.
- Undefined:
  - Writes set the effective volume directly.
  - No target registers are built.

## Test plan

All scenarios use the defaults: 4 channels, SAMPLE_W=9, VOL_W=4, OUT_W=10.

- Reset, all samples 100, mask 4'b1111, unity volume, strobe → o_sample=400, o_clip=0, valid exactly 6 cycles after the strobe.
- Volume ch0=4, sample0=200, mask 4'b0001 → o_sample=100; mask 4'b0000 → o_sample=0.
- All samples 511, all volumes 15, mask 4'b1111 → internal acc=3832, o_sample=1023, o_clip=1; next pass at unity with samples 10 → o_clip=0.
- Second strobe 2 cycles after the first → o_overrun pulse, a single o_sample_valid, result equals the first pass.
- Reset asserted in the cycle after the strobe → no o_sample_valid, all outputs 0; a following strobe gives the correct sum.
- Volume ramp, ch0 sample 80 with other channels masked, write ch0 volume 12 from 8, then 5 strobes:
  - With APU_MIXER_VOL_RAMP_EN → outputs 90, 100, 110, 120, 120.
  - Without the macro → outputs 120 for every pass.

Source files
------------

// File: rtl/apu_channel_mixer.sv
// apu_channel_mixer: strobe-driven, one-channel-per-clock volume mixer with saturation.
// Optional APU_MIXER_VOL_RAMP_EN: writes set targets; volumes step +/-1 per accepted strobe.
module apu_channel_mixer #(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_W     = 9,
  parameter int VOL_W        = 4,
  parameter int OUT_W        = 10,
  parameter int ADDR_W       = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_CHANNELS*SAMPLE_W-1:0] i_samples,
  input  logic [NUM_CHANNELS-1:0]          i_mixer,
  input  logic                             i_sample_stb,
  input  logic                             i_vol_we,
  input  logic [ADDR_W-1:0]                i_vol_addr,
  input  logic [VOL_W-1:0]                 i_vol_data,
  output logic [OUT_W-1:0]                 o_sample,
  output logic                             o_sample_valid,
  output logic                             o_clip,
  output logic                             o_busy,
  output logic                             o_overrun
);

  localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int ACC_W  = SAMPLE_W + VOL_W + $clog2(NUM_CHANNELS) + 1;
  localparam int PROD_W = SAMPLE_W + VOL_W;
  localparam logic [VOL_W-1:0] VOL_UNITY = VOL_W'(1 << (VOL_W - 1));
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [ACC_W-1:0]                 acc_q, acc_d;
  logic [NUM_CHANNELS*SAMPLE_W-1:0] samp_q, samp_d;
  logic [NUM_CHANNELS-1:0]          mask_q, mask_d;
  logic [VOL_W-1:0]                 vol_q [NUM_CHANNELS];
  logic [VOL_W-1:0]                 vol_d [NUM_CHANNELS];
`ifdef APU_MIXER_VOL_RAMP_EN
  logic [VOL_W-1:0]                 tgt_q [NUM_CHANNELS];
  logic [VOL_W-1:0]                 tgt_d [NUM_CHANNELS];
`endif
  logic [OUT_W-1:0]                 sample_q, sample_d;
  logic                             valid_q, valid_d;
  logic                             clip_q, clip_d;
  logic                             overrun_q, overrun_d;

  logic                             busy;
  logic                             accept;
  logic                             wr_ok;
  logic                             ovf;
  logic [SAMPLE_W-1:0]              cur_samp;
  logic [VOL_W-1:0]                 cur_vol;
  logic                             cur_en;
  logic [PROD_W-1:0]                prod;
  logic [PROD_W-1:0]                term;

  assign busy   = (state_q != IDLE);
  assign accept = i_sample_stb && !busy;
  assign wr_ok  = i_vol_we && (int'(i_vol_addr) < NUM_CHANNELS);

  always_comb begin
    cur_samp = '0;
    cur_vol  = '0;
    cur_en   = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_samp = samp_q[k*SAMPLE_W +: SAMPLE_W];
        cur_vol  = vol_q[k];
        cur_en   = mask_q[k];
      end
    end
  end

  assign prod = PROD_W'(cur_samp) * PROD_W'(cur_vol);
  assign term = cur_en ? (prod >> (VOL_W - 1)) : '0;
  // Any accumulator bit at or above OUT_W means the output saturates.
  assign ovf  = |(acc_q >> OUT_W);

  always_comb begin
    vol_d = vol_q;
`ifdef APU_MIXER_VOL_RAMP_EN
    tgt_d = tgt_q;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (wr_ok && (i_vol_addr == ADDR_W'(k))) begin
        tgt_d[k] = i_vol_data;
      end
    end
    if (accept) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (vol_q[k] < tgt_q[k]) begin
          vol_d[k] = vol_q[k] + VOL_W'(1);
        end else if (vol_q[k] > tgt_q[k]) begin
          vol_d[k] = vol_q[k] - VOL_W'(1);
        end
      end
    end
`else
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (wr_ok && (i_vol_addr == ADDR_W'(k))) begin
        vol_d[k] = i_vol_data;
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    samp_d    = samp_q;
    mask_d    = mask_q;
    sample_d  = sample_q;
    clip_d    = clip_q;
    valid_d   = 1'b0;
    overrun_d = i_sample_stb && busy;
    unique case (state_q)
      IDLE: begin
        if (i_sample_stb) begin
          samp_d  = i_samples;
          mask_d  = i_mixer;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + ACC_W'(term);
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        sample_d = ovf ? '1 : OUT_W'(acc_q);
        clip_d   = ovf;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      samp_q    <= '0;
      mask_q    <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        vol_q[k] <= VOL_UNITY;
`ifdef APU_MIXER_VOL_RAMP_EN
        tgt_q[k] <= VOL_UNITY;
`endif
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      samp_q    <= samp_d;
      mask_q    <= mask_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
      vol_q     <= vol_d;
`ifdef APU_MIXER_VOL_RAMP_EN
      tgt_q     <= tgt_d;
`endif
    end
  end

  assign o_sample       = sample_q;
  assign o_sample_valid = valid_q;
  assign o_clip         = clip_q;
  assign o_busy         = busy;
  assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_apu_channel_mixer.sv
// tb_apu_channel_mixer: scoreboard bench for apu_channel_mixer at default parameters.
// Expected passes are queued at strobe time and checked when o_sample_valid pulses.
`timescale 1ns/1ps
module tb_apu_channel_mixer;

  localparam int N  = 4;
  localparam int SW = 9;
  localparam int VW = 4;
  localparam int OW = 10;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*SW-1:0] i_samples = '0;
  logic [N-1:0]    i_mixer = '0;
  logic            i_sample_stb = 1'b0;
  logic            i_vol_we = 1'b0;
  logic [AW-1:0]   i_vol_addr = '0;
  logic [VW-1:0]   i_vol_data = '0;
  logic [OW-1:0]   o_sample;
  logic            o_sample_valid;
  logic            o_clip;
  logic            o_busy;
  logic            o_overrun;

  typedef struct {
    int s;
    int c;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   mvol[N];
  int   mtgt[N];
  int   exp_r[5];

  apu_channel_mixer #(
    .NUM_CHANNELS(N),
    .SAMPLE_W(SW),
    .VOL_W(VW),
    .OUT_W(OW),
    .ADDR_W(AW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_samples(i_samples),
    .i_mixer(i_mixer),
    .i_sample_stb(i_sample_stb),
    .i_vol_we(i_vol_we),
    .i_vol_addr(i_vol_addr),
    .i_vol_data(i_vol_data),
    .o_sample(o_sample),
    .o_sample_valid(o_sample_valid),
    .o_clip(o_clip),
    .o_busy(o_busy),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && o_sample_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sample", int'(o_sample), e.s);
        chk("clip", int'(o_clip), e.c);
        chk("latency", cyc - e.cyc, 6);
      end
    end
  end

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mvol[k] = 8;
      mtgt[k] = 8;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < N; k++) i_samples[k*SW +: SW] = SW'(v);
  endtask

  task automatic wr_vol(input int a, input int v);
    i_vol_we   = 1'b1;
    i_vol_addr = AW'(a);
    i_vol_data = VW'(v);
    @(negedge clk);
    i_vol_we = 1'b0;
`ifdef APU_MIXER_VOL_RAMP_EN
    mtgt[a] = v;
`else
    mvol[a] = v;
`endif
  endtask

  task automatic fire();
    int   acc;
    exp_t e;
`ifdef APU_MIXER_VOL_RAMP_EN
    for (int k = 0; k < N; k++) begin
      if (mvol[k] < mtgt[k]) mvol[k]++;
      else if (mvol[k] > mtgt[k]) mvol[k]--;
    end
`endif
    acc = 0;
    for (int k = 0; k < N; k++) begin
      if (i_mixer[k]) acc += (int'(i_samples[k*SW +: SW]) * mvol[k]) >> (VW - 1);
    end
    e.c   = (acc > 1023) ? 1 : 0;
    e.s   = (acc > 1023) ? 1023 : acc;
    e.cyc = cyc;
    sb.push_back(e);
    i_sample_stb = 1'b1;
    @(negedge clk);
    i_sample_stb = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || o_busy) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_sample", int'(o_sample), 0);
    chk("rst_valid", int'(o_sample_valid), 0);
    chk("rst_clip", int'(o_clip), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_overrun", int'(o_overrun), 0);

    set_all(100);
    i_mixer = 4'b1111;
    fire();
    chk("busy_in_pass", int'(o_busy), 1);
    drain();
    chk("sum400", int'(o_sample), 400);
    chk("busy_after", int'(o_busy), 0);

    wr_vol(0, 4);
    i_samples[0 +: SW] = SW'(200);
    i_mixer = 4'b0001;
    fire();
    drain();
    i_mixer = 4'b0000;
    fire();
    drain();
    chk("mute_all", int'(o_sample), 0);

    for (int k = 0; k < N; k++) wr_vol(k, 15);
    set_all(511);
    i_mixer = 4'b1111;
    fire();
    drain();
    for (int k = 0; k < N; k++) wr_vol(k, 8);
    set_all(10);
    fire();
    drain();
    chk("clip_cleared", int'(o_clip), 0);

    do_reset();
    for (int k = 0; k < N; k++) i_samples[k*SW +: SW] = SW'(50 + 10 * k);
    i_mixer = 4'b1111;
    fire();
    @(negedge clk);
    set_all(300);
    i_mixer = 4'b0011;
    i_sample_stb = 1'b1;
    @(negedge clk);
    i_sample_stb = 1'b0;
    chk("overrun_pulse", int'(o_overrun), 1);
    chk("busy_overrun", int'(o_busy), 1);
    @(negedge clk);
    chk("overrun_clear", int'(o_overrun), 0);
    drain();
    repeat (8) @(negedge clk);
    chk("overrun_result", int'(o_sample), 260);

    set_all(100);
    i_mixer = 4'b1111;
    fire();
    rst = 1'b1;
    sb.delete();
    model_reset();
    #1;
    chk("abort_sample", int'(o_sample), 0);
    chk("abort_clip", int'(o_clip), 0);
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_valid", int'(o_sample_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_valid_out", int'(o_sample), 0);
    for (int k = 0; k < N; k++) i_samples[k*SW +: SW] = SW'(20 * (k + 1));
    fire();
    drain();

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < N; k++) begin
        wr_vol(k, $urandom_range(0, 15));
        i_samples[k*SW +: SW] = SW'($urandom_range(0, 511));
      end
      i_mixer = N'($urandom_range(0, 15));
      fire();
      drain();
    end

`ifdef APU_MIXER_VOL_RAMP_EN
    exp_r = '{90, 100, 110, 120, 120};
`else
    exp_r = '{120, 120, 120, 120, 120};
`endif
    @(negedge clk);
    do_reset();
    set_all(0);
    i_samples[0 +: SW] = SW'(80);
    i_mixer = 4'b0001;
    wr_vol(0, 12);
    for (int t = 0; t < 5; t++) begin
      fire();
      drain();
      chk("ramp_out", int'(o_sample), exp_r[t]);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
